// File: rtl/masked_sbox_sched_pkg.sv
// Shared types and constants for the masked S-box scheduler.
package masked_sbox_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY   = 2'd1,
        STATE = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    localparam logic SEL_STATE = 1'b0;
    localparam logic SEL_KEY   = 1'b1;

    localparam int NUM_STATE_BYTES = 16;
    localparam int NUM_KEY_BYTES   = 4;

    // Byte-counter values at which a phase ends (5-bit counter).
    localparam logic [4:0] LAST_KEY_CNT   = 5'(NUM_KEY_BYTES - 1);
    localparam logic [4:0] LAST_STATE_CNT = 5'(NUM_STATE_BYTES - 1);
    localparam logic [3:0] LAST_STATE_IDX = 4'(NUM_STATE_BYTES - 1);

    typedef struct packed {
        logic       valid;
        logic       sel;
        logic [3:0] idx;
    } tag_t;

endpackage

// File: rtl/masked_sbox_sched_tag_pipe.sv
// sbox_tag_pipe: LAT-deep tag shift register that mirrors the masked S-box
// pipeline. All stages advance together on en and clear on async reset.
module sbox_tag_pipe
    import masked_sbox_sched_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [LAT];

    // Shift tags one stage per advancing cycle; hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else if (en) begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_out = stage_q[LAT-1];

endmodule

// File: rtl/masked_sbox_sched.sv
// masked_sbox_sched: issues key-schedule bytes then state bytes into the
// shared masked S-box and tracks them by tag until they return.
// Build option: MASKED_SBOX_SCHED_RND_STALL_EN makes rnd_valid gate every
// pipeline advance; otherwise rnd_valid is ignored.
//
// state | meaning
// IDLE  | waiting for start; S-box pipeline frozen
// KEY   | issuing key-schedule bytes 0..3
// STATE | issuing state bytes 0..15
// DRAIN | no issue; waiting for state byte 15 to return
module masked_sbox_sched
    import masked_sbox_sched_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       key_en,
    input  logic       rnd_valid,
    output logic       busy,
    output logic       done,
    output logic       issue_valid,
    output logic       issue_sel,
    output logic [3:0] issue_idx,
    output logic       sbox_en,
    output logic       ret_valid,
    output logic       ret_sel,
    output logic [3:0] ret_idx
);

    sched_state_t state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         adv;
    tag_t         issue_tag;
    tag_t         tail_tag;

`ifdef MASKED_SBOX_SCHED_RND_STALL_EN
    assign adv = rnd_valid;
`else
    logic unused_rnd_valid;
    assign unused_rnd_valid = rnd_valid;
    assign adv = 1'b1;
`endif

    // State and byte counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, issue and completion decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issue_valid = 1'b0;
        issue_sel   = SEL_STATE;
        issue_idx   = '0;
        done        = 1'b0;
        busy        = (state_q != IDLE);
        sbox_en     = busy & adv;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = key_en ? KEY : STATE;
            end
            KEY: begin
                if (adv) begin
                    issue_valid = 1'b1;
                    issue_sel   = SEL_KEY;
                    issue_idx   = cnt_q[3:0];
                    if (cnt_q == LAST_KEY_CNT) begin
                        state_d = STATE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            STATE: begin
                if (adv) begin
                    issue_valid = 1'b1;
                    issue_sel   = SEL_STATE;
                    issue_idx   = cnt_q[3:0];
                    if (cnt_q == LAST_STATE_CNT) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                if (adv && tail_tag.valid && tail_tag.sel == SEL_STATE &&
                    tail_tag.idx == LAST_STATE_IDX) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_tag = '{valid: issue_valid, sel: issue_sel, idx: issue_idx};

    sbox_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (sbox_en),
        .tag_in  (issue_tag),
        .tag_out (tail_tag)
    );

    // A return is only presented on an advancing cycle; tag fields are
    // zeroed otherwise so a stalled tail never looks like a result.
    assign ret_valid = tail_tag.valid & sbox_en;
    assign ret_sel   = ret_valid & tail_tag.sel;
    assign ret_idx   = ret_valid ? tail_tag.idx : 4'd0;

endmodule

// File: tb/tb_masked_sbox_sched.sv
// Scoreboard bench for masked_sbox_sched with LAT=4: the stimulus pushes the
// expected return sequence and done cycle per round, a negedge monitor pops
// and compares them whenever ret_valid or done appears.
module tb_masked_sbox_sched;
    localparam int LAT = 4;
`ifdef MASKED_SBOX_SCHED_RND_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       key_en = 1'b0;
    logic       rnd_valid = 1'b1;
    logic       busy, done, issue_valid, issue_sel, sbox_en, ret_valid, ret_sel;
    logic [3:0] issue_idx, ret_idx;

    masked_sbox_sched #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_en(key_en),
        .rnd_valid(rnd_valid), .busy(busy), .done(done),
        .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_idx(issue_idx),
        .sbox_en(sbox_en), .ret_valid(ret_valid), .ret_sel(ret_sel),
        .ret_idx(ret_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sel;
        logic [3:0] idx;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   t0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Relative cycle of the n-th advancing cycle when k stall cycles start at lo.
    function automatic int advc(input int n, input int lo, input int k);
        return (k == 0 || n < lo) ? n : n + k;
    endfunction

    task automatic push_round(input int base, input bit key, input int lo, input int k);
        int   nb;
        exp_t e;
        nb = key ? 20 : 16;
        for (int b = 0; b < nb; b++) begin
            e.sel = key && (b < 4);
            e.idx = 4'(key ? ((b < 4) ? b : b - 4) : b);
            e.at  = base + advc(b + 1 + LAT, lo, k);
            exp_q.push_back(e);
        end
        done_q.push_back(base + advc(nb + LAT, lo, k));
    endtask

    task automatic start_round(input bit key, input int lo, input int k);
        start  = 1'b1;
        key_en = key;
        t0     = cyc;
        push_round(t0, key, lo, k);
        tick(1);
        start = 1'b0;
    endtask

    task automatic check_empty(input string name);
        check({name, "_ret_q_empty"}, exp_q.size(), 0);
        check({name, "_done_q_empty"}, done_q.size(), 0);
    endtask

    // Monitor: pop and compare every return and done.
    exp_t m;
    int   md;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ret_valid) begin
                check("ret_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    m = exp_q.pop_front();
                    check("ret_sel", ret_sel, m.sel);
                    check("ret_idx", ret_idx, m.idx);
                    check("ret_cycle", cyc, m.at);
                end
            end
            if (done) begin
                check("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    md = done_q.pop_front();
                    check("done_cycle", cyc, md);
                    check("done_with_ret", ret_valid, 1);
                    check("done_last_ret", exp_q.size(), 0);
                end
            end
        end
    end

    int  cnt;
    bit  saw_key;
    int  dn;
    logic e_adv;

    initial begin
        // Reset state
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_sbox_en", sbox_en, 0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick(2);

        // Key + state round, no stalls
        start_round(1, 0, 0);
        check("s1_c1_issue_valid", issue_valid, 1);
        check("s1_c1_issue_sel", issue_sel, 1);
        check("s1_c1_issue_idx", issue_idx, 0);
        check("s1_c1_busy", busy, 1);
        tick(3);
        check("s1_c4_issue_sel", issue_sel, 1);
        check("s1_c4_issue_idx", issue_idx, 3);
        tick(1);
        check("s1_c5_issue_sel", issue_sel, 0);
        check("s1_c5_issue_idx", issue_idx, 0);
        tick(15);
        check("s1_c20_issue_idx", issue_idx, 15);
        tick(1);
        check("s1_c21_issue_valid", issue_valid, 0);
        check("s1_c21_busy", busy, 1);
        tick(3);
        check("s1_c24_busy", busy, 1);
        tick(1);
        check("s1_c25_busy", busy, 0);
        check("s1_c25_sbox_en", sbox_en, 0);
        check_empty("s1");
        tick(2);

        // State-only round
        start_round(0, 0, 0);
        saw_key = 1'b0;
        check("s2_c1_issue_sel", issue_sel, 0);
        check("s2_c1_issue_idx", issue_idx, 0);
        for (int r = 1; r <= 20; r++) begin
            saw_key |= issue_valid & issue_sel;
            tick(1);
        end
        check("s2_no_key_issue", saw_key, 0);
        check("s2_c21_busy", busy, 0);
        check_empty("s2");
        tick(2);

        // Three rnd_valid=0 cycles mid-STATE (cycles 8..10)
        start_round(1, 8, STALL_EN ? 3 : 0);
        e_adv = !STALL_EN;
        tick(7);
        for (int r = 8; r <= 10; r++) begin
            rnd_valid = 1'b0;
            #1;
            check("s3_stall_sbox_en", sbox_en, e_adv);
            check("s3_stall_issue_valid", issue_valid, e_adv);
            check("s3_stall_ret_valid", ret_valid, e_adv);
            tick(1);
        end
        rnd_valid = 1'b1;
        #1;
        check("s3_c11_issue_idx", issue_idx, STALL_EN ? 3 : 6);
        dn = STALL_EN ? 27 : 24;
        tick(dn - 11);
        check("s3_done_cycle_busy", busy, 1);
        tick(1);
        check("s3_after_done_busy", busy, 0);
        check_empty("s3");
        tick(2);

        // Reset mid-round at cycle 10
        start_round(1, 0, 0);
        tick(9);
        rst_n = 1'b0;
        #1;
        check("s4_rst_busy", busy, 0);
        check("s4_rst_issue_valid", issue_valid, 0);
        check("s4_rst_sbox_en", sbox_en, 0);
        check("s4_rst_ret_valid", ret_valid, 0);
        check("s4_rst_done", done, 0);
        exp_q.delete();
        done_q.delete();
        tick(2);
        rst_n = 1'b1;
        cnt = 0;
        for (int r = 0; r < 12; r++) begin
            cnt += int'(ret_valid) + int'(done) + int'(busy);
            tick(1);
        end
        check("s4_quiet_after_rst", cnt, 0);
        start_round(0, 0, 0);
        tick(20);
        check("s4_fresh_busy", busy, 0);
        check_empty("s4");
        tick(2);

        // start held high through the round, including the done cycle
        start  = 1'b1;
        key_en = 1'b1;
        t0     = cyc;
        push_round(t0, 1, 0, 0);
        tick(25);
        start = 1'b0;
        #1;
        check("s5_c25_busy", busy, 0);
        tick(1);
        check("s5_c26_busy", busy, 0);
        check_empty("s5");
        tick(2);

        // Back-to-back: next start at N+LAT+1
        start_round(1, 0, 0);
        tick(24);
        check("s6_c25_busy", busy, 0);
        start_round(0, 0, 0);
        check("s6_next_busy", busy, 1);
        check("s6_next_issue_valid", issue_valid, 1);
        check("s6_next_issue_idx", issue_idx, 0);
        tick(20);
        check("s6_next_end_busy", busy, 0);
        check_empty("s6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
